uart_echo_fifo: RTL and testbench
=================================

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameter PAYLOAD_BITS, default 8: width of each stored byte.
REQ-002 Parameter DEPTH, default 16: number of FIFO entries; power of two, minimum 2.
REQ-003 Parameter BUSY_TIMEOUT, default 3: cycles the drain FSM waits for tx_busy to rise before abandoning the wait.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_valid  in  1  one-cycle pulse from the UART receiver: rx_data is valid.
REQ-007 rx_data  in  PAYLOAD_BITS  received byte.
REQ-008 rx_break  in  1  qualifies rx_valid: the received frame was a BREAK.
REQ-009 tx_busy  in  1  UART transmitter is busy.
REQ-010 tx_en  out  1  registered one-cycle pulse to start transmitting tx_data.
REQ-011 tx_data  out  PAYLOAD_BITS  registered byte for the transmitter.
REQ-012 count  out  $clog2(DEPTH)+1  current number of stored bytes.
REQ-013 empty, full  out  1 each  count==0 and count==DEPTH respectively.
REQ-014 overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-015 break_seen  out  1  sticky flag: a BREAK frame was received.
REQ-016 flags_clr  in  1  clears overflow and break_seen on the next edge.

Function
REQ-017 Push: on an edge where rx_valid=1 and rx_break=0, the block shall write rx_data at the write pointer when count<DEPTH, or when a pop occurs on the same edge.
REQ-018 Push while full with no same-edge pop: the byte is dropped, count and pointers are unchanged, and overflow is set.
REQ-019 rx_valid=1 with rx_break=1: nothing is stored and break_seen is set.
REQ-020 The write and read pointers wrap modulo DEPTH; count is tracked separately, so full and empty are unambiguous.
REQ-021 Simultaneous push and pop: both pointers advance and count is unchanged.
REQ-022 Drain FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE: when empty=0 and tx_busy=0, on the edge the FSM loads tx_data with the head byte, asserts tx_en for exactly one cycle, pops, and goes to WAIT_BUSY.
REQ-024 WAIT_BUSY: goes to WAIT_DONE when tx_busy=1; goes to IDLE after BUSY_TIMEOUT cycles without tx_busy.
REQ-025 WAIT_DONE: goes to IDLE on the edge where tx_busy=0.
REQ-026 tx_data holds its value between issues; tx_en is never high on two consecutive cycles.
REQ-027 Latency: rx_valid in cycle 0 into an empty FIFO with tx_busy=0 gives tx_en high in cycle 2, with count=1 in cycle 1 and count=0 in cycle 3.
REQ-028 Bytes leave in arrival order; no byte is duplicated or lost except by REQ-018.
REQ-029 flags_clr on the same edge as a set event: set wins, so the flag stays 1.

Reset
REQ-030 While reset=1 at an edge: pointers=0, count=0, empty=1, full=0, tx_en=0, tx_data=0, overflow=0, break_seen=0, FSM=IDLE.
REQ-031 Reset takes priority over every push, pop, flag update and FSM transition on the same edge.
REQ-032 Reset mid-transfer: stored bytes are discarded and no tx_en is issued on the reset edge or the following edge.

Verification
REQ-033 Single byte 0x41, tx_busy=0: tx_en pulses in cycle 2 with tx_data=0x41, and count returns to 0.
REQ-034 Push 17 bytes 0x00..0x10 with tx_busy held 1: full=1 after 16 pushes, overflow=1, count=16; after releasing busy, the output order is 0x00..0x0F.
REQ-035 Break frame rx_valid=1 with rx_break=1 and rx_data=0x00: count stays 0, break_seen=1, no tx_en; then flags_clr=1 clears it.
REQ-036 FIFO full and push coinciding with a pop: count stays 16, overflow stays 0, and the new byte later appears in order.
REQ-037 tx_busy never rises after tx_en: the FSM returns to IDLE after 3 cycles and the next byte is issued.
REQ-038 Reset asserted with 5 bytes stored while in WAIT_DONE: next cycle count=0, empty=1, tx_en=0, FSM=IDLE.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// Echo buffer between a UART receiver and transmitter: incoming bytes are queued
// in a FIFO and drained one at a time, pacing each issue on the transmitter's busy line.
module uart_echo_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [PAYLOAD_BITS-1:0]   rx_data,
  input  logic                      rx_break,
  input  logic                      tx_busy,
  input  logic                      flags_clr,
  output logic                      tx_en,
  output logic [PAYLOAD_BITS-1:0]   tx_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      break_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [TW-1:0]           timer_reg, timer_next;
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]           count_reg;
  logic [PAYLOAD_BITS-1:0] tx_data_reg;
  logic                    tx_en_reg;
  logic                    overflow_reg, break_seen_reg;
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  logic push_req, push, pop, drop, brk;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign count      = count_reg;
  assign tx_en      = tx_en_reg;
  assign tx_data    = tx_data_reg;
  assign overflow   = overflow_reg;
  assign break_seen = break_seen_reg;

  // A push into a full FIFO is still accepted when the drain frees a slot on the same edge.
  assign push_req = rx_valid & ~rx_break;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign brk      = rx_valid & rx_break;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          timer_next = '0;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      tx_en_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      break_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      tx_en_reg <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // Set events win over a coincident clear.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (flags_clr) begin
        overflow_reg <= 1'b0;
      end
      if (brk) begin
        break_seen_reg <= 1'b1;
      end else if (flags_clr) begin
        break_seen_reg <= 1'b0;
      end
    end
  end

  // Storage carries no reset; reset discards contents by clearing the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= rx_data;
    end
  end

  // Registered read; when full, a same-edge write to the head slot returns the old byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_reg <= '0;
    end else if (pop) begin
      tx_data_reg <= mem[rd_ptr_reg];
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: latency, ordering, overflow, break handling,
// busy timeout and reset behaviour, with a simple transmitter busy model.
`timescale 1ns/1ps
module tb_uart_echo_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_break = 1'b0;
  logic       tx_busy;
  logic       flags_clr = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       empty, full, overflow, break_seen;

  logic       force_busy = 1'b0;
  logic       model_on = 1'b0;
  logic       model_busy = 1'b0;
  int         model_cnt = 0;
  logic       prev_en = 1'b0;
  logic [7:0] got [$];

  int checks = 0;
  int failures = 0;

  assign tx_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  uart_echo_fifo #(.PAYLOAD_BITS(8), .DEPTH(16), .BUSY_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .tx_busy(tx_busy), .flags_clr(flags_clr),
    .tx_en(tx_en), .tx_data(tx_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .break_seen(break_seen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_out(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("drain_count", got.size(), n);
  endtask

  // Collect issued bytes and flag back-to-back tx_en pulses.
  always @(negedge clk) begin
    if (tx_en) begin
      got.push_back(tx_data);
      check("tx_en_gap", prev_en, 1'b0);
    end
    prev_en = tx_en;
  end

  // Transmitter model: busy rises in the tx_en cycle and stays up for three more cycles.
  always @(negedge clk) begin
    if (!model_on) begin
      model_busy = 1'b0;
      model_cnt  = 0;
    end else if (tx_en) begin
      model_busy = 1'b1;
      model_cnt  = 3;
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_busy = 1'b0;
    end
  end

  initial begin
    logic [7:0] obs;
    // Reset state
    idle(2);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_break", break_seen, 0);
    reset = 1'b0;
    idle(2);

    // Single byte latency
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    tick();
    rx_valid = 1'b0;
    check("lat_c1_count", count, 1);
    check("lat_c1_tx_en", tx_en, 0);
    tick();
    check("lat_c2_tx_en", tx_en, 1);
    check("lat_c2_tx_data", tx_data, 8'h41);
    tick();
    check("lat_c3_count", count, 0);
    check("lat_c3_tx_en", tx_en, 0);
    idle(8);

    // Break frame, then clear; then set-wins on a coincident clear
    got.delete();
    rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'h00;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0;
    check("brk_count", count, 0);
    check("brk_flag", break_seen, 1);
    idle(5);
    check("brk_no_tx", got.size(), 0);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("brk_clr", break_seen, 0);
    rx_valid = 1'b1; rx_break = 1'b1; flags_clr = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0; flags_clr = 1'b0;
    check("brk_set_wins", break_seen, 1);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("brk_clr2", break_seen, 0);

    // Overflow with busy held high, then drain in order
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("ovf_full", full, 1);
    check("ovf_count16", count, 16);
    check("ovf_pre", overflow, 0);
    push(8'h10);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 16);
    got.delete();
    model_on = 1'b1;
    force_busy = 1'b0;
    wait_out(16, 400);
    for (int i = 0; i < 16; i++) begin
      obs = (i < got.size()) ? got[i] : 8'hxx;
      check($sformatf("ovf_order%0d", i), obs, i);
    end
    idle(10);
    check("ovf_drained_empty", empty, 1);
    check("ovf_drained_count", count, 0);
    model_on = 1'b0;
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Full FIFO: push coinciding with the first pop is accepted
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("pp_full", full, 1);
    got.delete();
    model_on = 1'b1;
    force_busy = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    tick();
    rx_valid = 1'b0;
    check("pp_count", count, 16);
    check("pp_overflow", overflow, 0);
    check("pp_tx_en", tx_en, 1);
    check("pp_tx_data", tx_data, 8'h10);
    wait_out(17, 400);
    for (int i = 0; i < 17; i++) begin
      obs = (i < got.size()) ? got[i] : 8'hxx;
      check($sformatf("pp_order%0d", i), obs, (i == 16) ? 8'hA5 : 8'(8'h10 + i));
    end
    idle(10);
    model_on = 1'b0;
    idle(4);

    // Busy never rises: three-cycle timeout back to IDLE, next byte four cycles later
    rx_valid = 1'b1;
    rx_data = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    check("to_c2_tx_en", tx_en, 1);
    check("to_c2_data", tx_data, 8'h11);
    for (int k = 3; k <= 7; k++) begin
      tick();
      check($sformatf("to_c%0d_tx_en", k), tx_en, (k == 6) ? 1'b1 : 1'b0);
    end
    check("to_c7_data", tx_data, 8'h22);
    idle(6);

    // Reset while in WAIT_DONE with five bytes stored
    push(8'h51);
    tick();
    check("wd_issue", tx_en, 1);
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    check("wd_count5", count, 5);
    reset = 1'b1;
    tick();
    check("wd_rst_count", count, 0);
    check("wd_rst_empty", empty, 1);
    check("wd_rst_tx_en", tx_en, 0);
    check("wd_rst_tx_data", tx_data, 0);
    reset = 1'b0;
    force_busy = 1'b0;
    tick();
    check("wd_post1_tx_en", tx_en, 0);
    tick();
    check("wd_post2_tx_en", tx_en, 0);
    push(8'h77);
    tick();
    check("wd_idle_tx_en", tx_en, 1);
    check("wd_idle_data", tx_data, 8'h77);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
